// File: rtl/core_inst_seq_pkg.sv
// Shared definitions for the core instruction sequencer: inst word layout,
// idle word and sequencer state encoding.
package core_pkg;

    localparam int INST_W = 36;
    localparam int A_W    = 11;

    localparam int IDX_ACC        = 33;
    localparam int IDX_CEN_PMEM   = 32;
    localparam int IDX_WEN_PMEM   = 31;
    localparam int IDX_A_PMEM_LSB = 20;
    localparam int IDX_CEN_XMEM   = 19;
    localparam int IDX_WEN_XMEM   = 18;
    localparam int IDX_A_XMEM_LSB = 7;
    localparam int IDX_OFIFO_RD   = 6;
    localparam int IDX_IFIFO_WR   = 5;
    localparam int IDX_IFIFO_RD   = 4;
    localparam int IDX_L0_RD      = 3;
    localparam int IDX_L0_WR      = 2;
    localparam int IDX_EXECUTE    = 1;
    localparam int IDX_LOAD       = 0;

    // Both SRAMs deselected with write disabled; every other field zero.
    localparam logic [INST_W-1:0] INST_IDLE =
        (INST_W'(1) << IDX_CEN_PMEM) | (INST_W'(1) << IDX_WEN_PMEM) |
        (INST_W'(1) << IDX_CEN_XMEM) | (INST_W'(1) << IDX_WEN_XMEM);

    typedef enum logic [2:0] {
        IDLE,
        WLD,
        KLD,
        ALD,
        EXE,
        DRN,
        FIN
    } state_t;

endpackage

// File: rtl/core_inst_seq_if.sv
// Host-facing bundle of the sequencer: pass setup, OFIFO status and the
// registered instruction word / status outputs.
interface core_inst_seq_if #(
    parameter int aw = 11,
    parameter int nw = 11
);
    import core_pkg::*;

    logic              start;
    logic [aw-1:0]     w_base;
    logic [aw-1:0]     a_base;
    logic [aw-1:0]     p_base;
    logic [nw-1:0]     n_act;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;

    modport master (
        output start, w_base, a_base, p_base, n_act, ofifo_valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, w_base, a_base, p_base, n_act, ofifo_valid,
        output inst, busy, done
    );

endinterface

// File: rtl/core_inst_seq_xmem_l0_stream.sv
// Pipelined xmem-read / l0-write counter: len reads from base+0.., each l0
// write one cycle behind its read; runs len+1 cycles while en is held.
module xmem_l0_stream #(
    parameter int aw = 11,
    parameter int nw = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [aw-1:0] base,
    input  logic [nw-1:0] len,
    output logic          rd,
    output logic [aw-1:0] addr,
    output logic          l0_wr,
    output logic          last
);

    logic [nw:0] cnt;

    assign rd    = en && (cnt < {1'b0, len});
    assign l0_wr = en && (cnt != '0);
    assign last  = en && (cnt == {1'b0, len});
    assign addr  = base + aw'(cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer for core: kernel load, activation load, execute and
// OFIFO drain to pmem for one tile pass, emitting a registered inst word.
module core_inst_seq
    import core_pkg::*;
#(
    parameter int row = 8,
    parameter int col = 8,
    parameter int aw  = 11,
    parameter int nw  = 11
) (
    input  logic             clk,
    input  logic             reset,
    core_inst_seq_if.slave   io
);

    state_t            state, state_n;
    logic [nw:0]       cnt, cnt_n;
    logic [nw:0]       rcnt, rcnt_n;
    logic [nw:0]       wcnt, wcnt_n;
    logic              pend, pend_n;
    logic [aw-1:0]     wb, ab, pb;
    logic [nw-1:0]     nq;
    logic [INST_W-1:0] inst_q, inst_n;
    logic              busy_q, done_q, done_n;

    logic              s_en, s_rd, s_wr, s_last;
    logic [aw-1:0]     s_base, s_addr;
    logic [nw-1:0]     s_len;
    logic              drn_rd;

    assign s_en   = (state == WLD) || (state == ALD);
    assign s_base = (state == WLD) ? wb : ab;
    assign s_len  = (state == WLD) ? nw'(row) : nq;

    xmem_l0_stream #(
        .aw (aw),
        .nw (nw)
    ) u_stream (
        .clk   (clk),
        .reset (reset),
        .en    (s_en),
        .base  (s_base),
        .len   (s_len),
        .rd    (s_rd),
        .addr  (s_addr),
        .l0_wr (s_wr),
        .last  (s_last)
    );

    assign drn_rd = io.ofifo_valid && (rcnt < {1'b0, nq});

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rcnt_n  = rcnt;
        wcnt_n  = wcnt;
        pend_n  = pend;
        inst_n  = INST_IDLE;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (io.start) begin
                    state_n = WLD;
                    cnt_n   = '0;
                    rcnt_n  = '0;
                    wcnt_n  = '0;
                    pend_n  = 1'b0;
                end
            end
            WLD, ALD: begin
                if (s_rd) begin
                    inst_n[IDX_CEN_XMEM]                = 1'b0;
                    inst_n[IDX_A_XMEM_LSB +: aw] = s_addr;
                end
                inst_n[IDX_L0_WR] = s_wr;
                if (s_last) begin
                    state_n = (state == WLD) ? KLD : EXE;
                    cnt_n   = '0;
                end
            end
            KLD: begin
                // col shift cycles, then one idle bubble before activations
                if (cnt < (nw+1)'(col)) begin
                    inst_n[IDX_L0_RD] = 1'b1;
                    inst_n[IDX_LOAD]  = 1'b1;
                    cnt_n             = cnt + 1'b1;
                end else begin
                    cnt_n   = '0;
                    state_n = (nq == '0) ? FIN : ALD;
                end
            end
            EXE: begin
                inst_n[IDX_L0_RD]   = 1'b1;
                inst_n[IDX_EXECUTE] = 1'b1;
                cnt_n               = cnt + 1'b1;
                if (cnt == {1'b0, nq} - 1'b1) begin
                    state_n = DRN;
                    cnt_n   = '0;
                    rcnt_n  = '0;
                    wcnt_n  = '0;
                    pend_n  = 1'b0;
                end
            end
            DRN: begin
                // pend marks an OFIFO read issued last cycle whose data is
                // now on the bus and must be written to pmem
                inst_n[IDX_OFIFO_RD] = drn_rd;
                if (drn_rd) begin
                    rcnt_n = rcnt + 1'b1;
                end
                pend_n = drn_rd;
                if (pend) begin
                    inst_n[IDX_CEN_PMEM]                = 1'b0;
                    inst_n[IDX_WEN_PMEM]                = 1'b0;
                    inst_n[IDX_A_PMEM_LSB +: aw] = pb + aw'(wcnt);
                    wcnt_n = wcnt + 1'b1;
                    if (wcnt_n == {1'b0, nq}) begin
                        state_n = FIN;
                    end
                end
            end
            FIN: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rcnt   <= '0;
            wcnt   <= '0;
            pend   <= 1'b0;
            wb     <= '0;
            ab     <= '0;
            pb     <= '0;
            nq     <= '0;
            inst_q <= INST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rcnt   <= rcnt_n;
            wcnt   <= wcnt_n;
            pend   <= pend_n;
            inst_q <= inst_n;
            busy_q <= (state_n != IDLE);
            done_q <= done_n;
            if (state == IDLE && io.start) begin
                wb <= io.w_base;
                ab <= io.a_base;
                pb <= io.p_base;
                nq <= io.n_act;
            end
        end
    end

    assign io.inst = inst_q;
    assign io.busy = busy_q;
    assign io.done = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq: each pass pushes its expected inst/busy/
// done trace, a negedge monitor pops and compares every cycle.
module tb_core_inst_seq;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int NW  = 11;

    localparam logic [35:0] IDLE_W =
        (36'd1 << 32) | (36'd1 << 31) | (36'd1 << 19) | (36'd1 << 18);

    typedef struct packed {
        logic [35:0] inst;
        logic        busy;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    core_inst_seq_if #(.aw(AW), .nw(NW)) bus ();

    core_inst_seq #(
        .row (ROW),
        .col (COL),
        .aw  (AW),
        .nw  (NW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    exp_t exp_q[$];
    bit   dir_v[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    function automatic logic [35:0] mk(bit xrd, logic [10:0] xa, bit l0wr,
                                       bit l0rd, bit ld, bit ex, bit ofr,
                                       bit pwr, logic [10:0] pa);
        logic [35:0] r;
        r = '0;
        r[32] = ~pwr;
        r[31] = ~pwr;
        if (pwr) r[30:20] = pa;
        r[19] = ~xrd;
        r[18] = 1'b1;
        if (xrd) r[17:7] = xa;
        r[6] = ofr;
        r[3] = l0rd;
        r[2] = l0wr;
        r[1] = ex;
        r[0] = ld;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e.inst = IDLE_W;
                e.busy = 1'b0;
                e.done = 1'b0;
            end
            a.inst = bus.inst;
            a.busy = bus.busy;
            a.done = bus.done;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL trace t=%0t got inst=%h busy=%b done=%b want inst=%h busy=%b done=%b",
                         $time, a.inst, a.busy, a.done, e.inst, e.busy, e.done);
            end
        end
    end

    // vmode: 0 ofifo_valid always 1, 1 random, 2 from dir_v
    task automatic run_pass(input logic [10:0] wb, input logic [10:0] ab,
                            input logic [10:0] pb, input int n, input int vmode,
                            input int rst_at, input int xstart_at);
        logic [35:0] cw[$];
        bit          v[$];
        int          d, t, r, w, g;
        bit          pend, rd, vb;
        exp_t        e;

        for (int k = 0; k <= ROW; k++)
            cw.push_back(mk(k < ROW, wb + 11'(k), k > 0, 0, 0, 0, 0, 0, '0));
        for (int k = 0; k < COL; k++)
            cw.push_back(mk(0, '0, 0, 1, 1, 0, 0, 0, '0));
        cw.push_back(IDLE_W);
        d = -1;
        if (n > 0) begin
            for (int k = 0; k <= n; k++)
                cw.push_back(mk(k < n, ab + 11'(k), k > 0, 0, 0, 0, 0, 0, '0));
            for (int k = 0; k < n; k++)
                cw.push_back(mk(0, '0, 0, 1, 0, 1, 0, 0, '0));
            d = cw.size();
            r = 0;
            w = 0;
            pend = 0;
            while (w < n) begin
                if (vmode == 0) vb = 1;
                else if (vmode == 2) vb = (v.size() < dir_v.size()) ? dir_v[v.size()] : 1'b1;
                else vb = ($urandom_range(0, 2) != 0);
                if (v.size() > 60) vb = 1;
                rd = vb && (r < n);
                cw.push_back(mk(0, '0, 0, 0, 0, 0, rd, pend, pb + 11'(w)));
                if (pend) w++;
                if (rd) r++;
                pend = rd;
                v.push_back(vb);
            end
        end
        cw.push_back(IDLE_W);
        t = cw.size();

        @(negedge clk);
        #1;
        bus.w_base = wb;
        bus.a_base = ab;
        bus.p_base = pb;
        bus.n_act  = NW'(n);
        bus.start  = 1'b1;
        e.inst = IDLE_W;
        e.busy = 1'b1;
        e.done = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < t; i++) begin
            e.inst = cw[i];
            e.busy = (i != t - 1);
            e.done = (i == t - 1);
            exp_q.push_back(e);
        end

        for (int c = 0; c < t; c++) begin
            @(negedge clk);
            #1;
            bus.start = (c == xstart_at);
            if (rst_at >= 0 && c == rst_at + 1) begin
                reset = 1'b0;
                break;
            end
            if (d >= 0 && c >= d && (c - d) < v.size()) bus.ofifo_valid = v[c - d];
            else bus.ofifo_valid = 1'($urandom);
            if (c == rst_at) begin
                reset = 1'b1;
                exp_q.delete();
            end
        end
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        reset = 1'b0;
        g = 0;
        while (exp_q.size() > 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left=%0d entries want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.w_base      = '0;
        bus.a_base      = '0;
        bus.p_base      = '0;
        bus.n_act       = '0;
        bus.ofifo_valid = 1'b0;
        reset           = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        run_pass(11'h100, 11'h000, 11'h000, 0, 0, -1, -1);
        run_pass(11'h100, 11'h7FE, 11'h010, 4, 0, -1, -1);
        dir_v = '{1, 0, 0, 1, 0, 1};
        run_pass(11'h020, 11'h300, 11'h400, 3, 2, -1, -1);
        run_pass(11'h100, 11'h200, 11'h050, 4, 0, ROW + COL + 4 + 4, -1);
        run_pass(11'h100, 11'h200, 11'h050, 4, 0, -1, -1);
        run_pass(11'h0F0, 11'h7FC, 11'h7FE, 5, 1, -1, ROW + COL + 3);
        for (int p = 0; p < 8; p++) begin
            run_pass(11'($urandom), 11'($urandom), 11'($urandom),
                     $urandom_range(0, 6), 1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
